// File: rtl/frog_move_ctrl.sv
// Frog move controller: synchronizes and debounces four active-low buttons, then issues one move per press.
// Latency: a press first sampled at edge k gives move_valid after edge k+DEBOUNCE_CYCLES+2; move_dir is held until move_ready.
// Backpressure: stays in ISSUE until move_ready. Presses while busy are dropped unless FROG_MOVE_QUEUE_EN adds a 1-entry pending slot.
module frog_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       busy
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] CD_LOAD  = 8'(COOLDOWN_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

  logic [3:0] btn;
  logic [3:0] sync1, sync2, deb, press_q;
  logic [7:0] cnt [4];

  state_t     state, state_n;
  logic [1:0] dir_q, dir_n;
  logic [7:0] cd_cnt, cd_n;
  logic       ev;
  logic [1:0] ev_dir;

  // bit index equals the direction code: up=0, down=1, left=2, right=3
  assign btn = {right, left, down, up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 4'hF;
      sync2   <= 4'hF;
      deb     <= 4'hF;
      press_q <= 4'h0;
      for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      press_q <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            cnt[i]     <= 8'd0;
            // only a released->pressed change is an event
            press_q[i] <= deb[i];
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= 8'd0;
        end
      end
    end
  end

  always_comb begin
    ev     = 1'b1;
    ev_dir = 2'd0;
    if (press_q[0])      ev_dir = 2'd0;
    else if (press_q[1]) ev_dir = 2'd1;
    else if (press_q[2]) ev_dir = 2'd2;
    else if (press_q[3]) ev_dir = 2'd3;
    else                 ev     = 1'b0;
  end

`ifdef FROG_MOVE_QUEUE_EN
  logic       pend_vld;
  logic [1:0] pend_dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_dir <= 2'd0;
    end else if (state != IDLE && ev) begin
      pend_vld <= 1'b1;
      pend_dir <= ev_dir;
    end else if (state == IDLE && pend_vld) begin
      pend_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      dir_q  <= 2'd0;
      cd_cnt <= 8'd0;
    end else begin
      state  <= state_n;
      dir_q  <= dir_n;
      cd_cnt <= cd_n;
    end
  end

  always_comb begin
    state_n    = state;
    dir_n      = dir_q;
    cd_n       = cd_cnt;
    move_valid = 1'b0;
    case (state)
      IDLE: begin
`ifdef FROG_MOVE_QUEUE_EN
        if (pend_vld) begin
          dir_n   = pend_dir;
          state_n = ISSUE;
        end else
`endif
        if (ev) begin
          dir_n   = ev_dir;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        move_valid = 1'b1;
        if (move_ready) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            state_n = COOLDOWN;
            cd_n    = CD_LOAD;
          end
        end
      end
      COOLDOWN: begin
        // counts CD_LOAD down to 0; the zero cycle is the return-to-IDLE cycle
        if (cd_cnt == 8'd0) state_n = IDLE;
        else                cd_n    = cd_cnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign move_dir = dir_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Directed bench for frog_move_ctrl at default parameters; move counts come from a negedge monitor.
module tb_frog_move_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       up, down, left, right;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       busy;

  int cyc = 0;
  int mv_cnt = 0;
  int total = 0;
  int bad = 0;
  int m0;
  bit seen;

  frog_move_ctrl dut (
    .clk(clk), .reset(reset),
    .up(up), .down(down), .left(left), .right(right),
    .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (move_valid === 1'b1) mv_cnt <= mv_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_all;
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1;
  endtask

  task automatic wait_mv(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      tick;
      if (move_valid === 1'b1) got = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    release_all;
    move_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick;
    chk("rst_valid", move_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dir", move_dir, 0);
    reset = 1'b0;

    // up held from edge 100: one-cycle move after edge 106, busy through edge 115
    while (cyc < 99) tick;
    up = 1'b0;
    for (int e = 100; e <= 118; e++) begin
      tick;
      chk("t1_valid", move_valid, (e == 106));
      chk("t1_busy", busy, (e >= 106 && e <= 115));
      if (e == 106) chk("t1_dir", move_dir, 2'd0);
    end
    release_all;
    repeat (20) tick;

    // short left pulses never debounce
    m0 = mv_cnt;
    for (int p = 0; p < 4; p++) begin
      left = 1'b0;
      repeat (3) tick;
      left = 1'b1;
      tick;
    end
    repeat (15) tick;
    chk("t2_nomove", mv_cnt - m0, 0);

    // down and right together: down wins, single move
    down = 1'b0; right = 1'b0;
    wait_mv(20, seen);
    chk("t3_seen", seen, 1);
    chk("t3_dir", move_dir, 2'd1);
    m0 = mv_cnt;
    repeat (30) tick;
    chk("t3_once", mv_cnt - m0, 1);
    release_all;
    repeat (20) tick;

    // backpressure: valid and dir held for 20 cycles
    move_ready = 1'b0;
    left = 1'b0;
    wait_mv(20, seen);
    chk("t4_seen", seen, 1);
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("t4_hold_valid", move_valid, 1);
      chk("t4_hold_dir", move_dir, 2'd2);
    end
    move_ready = 1'b1;
    tick;
    chk("t4_hs_valid", move_valid, 0);
    chk("t4_hs_busy", busy, 1);
    release_all;
    repeat (25) tick;

    // reset during cooldown aborts, then a fresh up press issues normally
    left = 1'b0;
    wait_mv(20, seen);
    chk("t5_seen", seen, 1);
    left = 1'b1;
    repeat (3) tick;
    chk("t5_cool_busy", busy, 1);
    reset = 1'b1;
    tick;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", move_valid, 0);
    chk("t5_rst_dir", move_dir, 0);
    reset = 1'b0;
    up = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      chk("t5_valid", move_valid, (i == 7));
    end
    chk("t5_dir", move_dir, 2'd0);
    repeat (20) tick;

    // up still held through a reset pulse: exactly one more move
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m0 = mv_cnt;
    repeat (30) tick;
    chk("t6_once", mv_cnt - m0, 1);
    release_all;
    repeat (20) tick;

    // right pressed during cooldown
    up = 1'b0;
    wait_mv(20, seen);
    chk("t7_seen", seen, 1);
    up = 1'b1;
    right = 1'b0;
    repeat (10) tick;
    chk("t7_pre_valid", move_valid, 0);
    tick;
`ifdef FROG_MOVE_QUEUE_EN
    chk("t7_valid", move_valid, 1);
    chk("t7_dir", move_dir, 2'd3);
`else
    chk("t7_valid", move_valid, 0);
    m0 = mv_cnt;
    repeat (20) tick;
    chk("t7_nomove", mv_cnt - m0, 0);
`endif
    release_all;
    repeat (20) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
